// File: rtl/seg_scan_display.sv
// Multiplexed 6-digit common-cathode 7-segment driver with a guard-blank cycle per slot,
// per-frame snapshot of the character codes, decimal points and whole-display blink.
module seg_scan_display #(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLINK_FRAMES = 83
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       blink_en,
   input  logic [5:0] Seg1,
   input  logic [5:0] Seg2,
   input  logic [5:0] Seg3,
   input  logic [5:0] Seg4,
   input  logic [5:0] Seg5,
   input  logic [5:0] Seg6,
   input  logic [5:0] dp_mask,
   output logic [7:0] seg,
   output logic [5:0] dig_n,
   output logic       frame_done
);

   localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned FRM_W = (BLINK_FRAMES > 0) ? $clog2(BLINK_FRAMES + 1) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
   localparam logic [2:0]       IDX_LAST = 3'd5;

   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [5:0][5:0]  shadow_q, shadow_d;
   logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             blink_ph_q, blink_ph_d;
   logic [7:0]       seg_q, seg_d;
   logic [5:0]       dig_n_q, dig_n_d;
   logic             frame_done_q, frame_done_d;

   logic [5:0][5:0]  codes_c;
   logic             wrap_c;
   logic             blank_c;

   // Slot k of codes_c is Seg(k+1), so Seg1 lands on the leftmost digit.
   assign codes_c = {Seg6, Seg5, Seg4, Seg3, Seg2, Seg1};
   assign wrap_c  = enable && (pre_cnt_q == PRE_LAST) && (idx_q == IDX_LAST);
   assign blank_c = !enable || (pre_cnt_q == '0) || blink_ph_q;

   function automatic logic [6:0] decode(input logic [5:0] code);
      case (code)
         6'h00:   decode = 7'h3F;
         6'h01:   decode = 7'h06;
         6'h02:   decode = 7'h5B;
         6'h03:   decode = 7'h4F;
         6'h04:   decode = 7'h66;
         6'h05:   decode = 7'h6D;
         6'h06:   decode = 7'h7D;
         6'h07:   decode = 7'h07;
         6'h08:   decode = 7'h7F;
         6'h09:   decode = 7'h6F;
         6'h0A:   decode = 7'h71;
         6'h0B:   decode = 7'h77;
         6'h0C:   decode = 7'h7C;
         6'h0D:   decode = 7'h39;
         6'h0E:   decode = 7'h5E;
         6'h0F:   decode = 7'h79;
         6'h10:   decode = 7'h76;
         6'h14:   decode = 7'h1E;
         6'h16:   decode = 7'h38;
         6'h18:   decode = 7'h54;
         6'h1C:   decode = 7'h50;
         6'h1D:   decode = 7'h6D;
         6'h21:   decode = 7'h3E;
         6'h23:   decode = 7'h6E;
         default: decode = 7'h00;
      endcase
   endfunction

   always_comb begin
      pre_cnt_d    = pre_cnt_q;
      idx_d        = idx_q;
      shadow_d     = shadow_q;
      frame_cnt_d  = frame_cnt_q;
      blink_ph_d   = blink_ph_q;
      frame_done_d = 1'b0;

      // Scan counters; shadow tracks the inputs while idle so slot 0 is valid on enable.
      if (!enable) begin
         pre_cnt_d = '0;
         idx_d     = '0;
         shadow_d  = codes_c;
      end else if (pre_cnt_q == PRE_LAST) begin
         pre_cnt_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d        = '0;
            shadow_d     = codes_c;
            frame_done_d = 1'b1;
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end else begin
         pre_cnt_d = pre_cnt_q + PRE_W'(1);
      end

      if (!blink_en) begin
         frame_cnt_d = '0;
         blink_ph_d  = 1'b0;
      end else if (wrap_c) begin
         if (frame_cnt_q == FRM_LAST) begin
            frame_cnt_d = '0;
            blink_ph_d  = !blink_ph_q;
         end else begin
            frame_cnt_d = frame_cnt_q + FRM_W'(1);
         end
      end

      // First cycle of every slot stays dark to avoid ghosting between digits.
      dig_n_d = blank_c ? 6'h3F : ~(6'b1 << idx_q);
      seg_d   = blank_c ? 8'h00 : {dp_mask[idx_q], decode(shadow_q[idx_q])};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt_q    <= '0;
         idx_q        <= '0;
         shadow_q     <= {6{6'h3F}};
         frame_cnt_q  <= '0;
         blink_ph_q   <= 1'b0;
         seg_q        <= 8'h00;
         dig_n_q      <= 6'h3F;
         frame_done_q <= 1'b0;
      end else begin
         pre_cnt_q    <= pre_cnt_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         frame_cnt_q  <= frame_cnt_d;
         blink_ph_q   <= blink_ph_d;
         seg_q        <= seg_d;
         dig_n_q      <= dig_n_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg        = seg_q;
   assign dig_n      = dig_n_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with SCAN_DIV=4, BLINK_FRAMES=2 (24-cycle frames).
module tb_seg_scan_display;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       blink_en;
   logic [5:0] seg1, seg2, seg3, seg4, seg5, seg6;
   logic [5:0] dp_mask;
   logic [7:0] seg;
   logic [5:0] dig_n;
   logic       frame_done;

   int errors = 0;
   int checks = 0;
   logic [5:0] dig_tab [6];

   always #5 clk = ~clk;

   seg_scan_display #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
      .clk(clk), .rst(rst), .enable(enable), .blink_en(blink_en),
      .Seg1(seg1), .Seg2(seg2), .Seg3(seg3), .Seg4(seg4), .Seg5(seg5), .Seg6(seg6),
      .dp_mask(dp_mask), .seg(seg), .dig_n(dig_n), .frame_done(frame_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; blink_en = 1'b0; dp_mask = 6'h00;
      {seg1, seg2, seg3, seg4, seg5, seg6} = {6{6'h3F}};
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (seg !== 8'h00) begin errors++; $display("FAIL reset seg cyc=%0d got=%h want=00", i, seg); end
         checks++;
         if (dig_n !== 6'h3F) begin errors++; $display("FAIL reset dig_n cyc=%0d got=%h want=3F", i, dig_n); end
         checks++;
         if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done cyc=%0d got=%b want=0", i, frame_done); end
      end
      rst = 1'b0;
   endtask

   // Two frames of "CALSEn" starting from enable rising.
   task automatic test_scan();
      logic [7:0] exp_seg [6];
      logic [7:0] e_seg;
      logic [5:0] e_dig;
      logic       e_fd;
      exp_seg = '{8'h39, 8'h77, 8'h38, 8'h6D, 8'h79, 8'h54};
      {seg1, seg2, seg3, seg4, seg5, seg6} = {6'h0D, 6'h0B, 6'h16, 6'h1D, 6'h0F, 6'h18};
      tick();
      checks++;
      if (dig_n !== 6'h3F || seg !== 8'h00) begin
         errors++; $display("FAIL idle dark got dig_n=%h seg=%h want 3F/00", dig_n, seg);
      end
      enable = 1'b1;
      for (int c = 0; c < 48; c++) begin
         tick();
         e_dig = ((c % 4) != 0) ? dig_tab[(c % 24) / 4] : 6'h3F;
         e_seg = ((c % 4) != 0) ? exp_seg[(c % 24) / 4] : 8'h00;
         e_fd  = ((c % 24) == 23);
         checks++;
         if (dig_n !== e_dig) begin errors++; $display("FAIL scan dig_n c=%0d got=%h want=%h", c, dig_n, e_dig); end
         checks++;
         if (seg !== e_seg) begin errors++; $display("FAIL scan seg c=%0d got=%h want=%h", c, seg, e_seg); end
         checks++;
         if (frame_done !== e_fd) begin errors++; $display("FAIL scan frame_done c=%0d got=%b want=%b", c, frame_done, e_fd); end
      end
   endtask

   // Mid-frame code changes only appear after the next wrap.
   task automatic test_shadow();
      logic [7:0] exp_a [6];
      logic [7:0] exp_b [6];
      logic [7:0] e_seg;
      logic [5:0] e_dig;
      logic       e_fd;
      exp_a = '{8'h39, 8'h77, 8'h38, 8'h6D, 8'h79, 8'h54};
      exp_b = '{8'h3F, 8'h77, 8'h38, 8'h6D, 8'h76, 8'h54};
      for (int c = 0; c < 48; c++) begin
         tick();
         e_dig = ((c % 4) != 0) ? dig_tab[(c % 24) / 4] : 6'h3F;
         e_seg = ((c % 4) == 0) ? 8'h00 : (c < 24) ? exp_a[c / 4] : exp_b[(c - 24) / 4];
         e_fd  = ((c % 24) == 23);
         checks++;
         if (dig_n !== e_dig) begin errors++; $display("FAIL shadow dig_n c=%0d got=%h want=%h", c, dig_n, e_dig); end
         checks++;
         if (seg !== e_seg) begin errors++; $display("FAIL shadow seg c=%0d got=%h want=%h", c, seg, e_seg); end
         checks++;
         if (frame_done !== e_fd) begin errors++; $display("FAIL shadow frame_done c=%0d got=%b want=%b", c, frame_done, e_fd); end
         if (c == 9) begin
            seg1 = 6'h00;
            seg5 = 6'h10;
         end
      end
   endtask

   // Two lit frames, two dark frames, then lit again; frame_done never stops.
   task automatic test_blink();
      logic [7:0] exp_seg [6];
      logic [7:0] e_seg;
      logic [5:0] e_dig;
      logic       e_fd;
      logic       lit;
      exp_seg = '{8'h3F, 8'h77, 8'h38, 8'h6D, 8'h76, 8'h54};
      blink_en = 1'b1;
      for (int c = 0; c < 120; c++) begin
         tick();
         lit   = ((c % 4) != 0) && (c / 24 != 2) && (c / 24 != 3);
         e_dig = lit ? dig_tab[(c % 24) / 4] : 6'h3F;
         e_seg = lit ? exp_seg[(c % 24) / 4] : 8'h00;
         e_fd  = ((c % 24) == 23);
         checks++;
         if (dig_n !== e_dig) begin errors++; $display("FAIL blink dig_n c=%0d got=%h want=%h", c, dig_n, e_dig); end
         checks++;
         if (seg !== e_seg) begin errors++; $display("FAIL blink seg c=%0d got=%h want=%h", c, seg, e_seg); end
         checks++;
         if (frame_done !== e_fd) begin errors++; $display("FAIL blink frame_done c=%0d got=%b want=%b", c, frame_done, e_fd); end
      end
   endtask

   // Unknown codes decode blank, dp still lights on a blank code, digits/letters decode.
   task automatic test_dp_blank();
      logic [7:0] exp_seg [6];
      logic [7:0] e_seg;
      logic [5:0] e_dig;
      logic       e_fd;
      exp_seg = '{8'h00, 8'h00, 8'h80, 8'h6D, 8'h3F, 8'h6F};
      enable = 1'b0; blink_en = 1'b0;
      tick();
      checks++;
      if (dig_n !== 6'h3F || seg !== 8'h00 || frame_done !== 1'b0) begin
         errors++; $display("FAIL disable dark got dig_n=%h seg=%h fd=%b want 3F/00/0", dig_n, seg, frame_done);
      end
      {seg1, seg2, seg3, seg4, seg5, seg6} = {6'h3F, 6'h11, 6'h2A, 6'h05, 6'h00, 6'h09};
      dp_mask = 6'b000100;
      tick();
      enable = 1'b1;
      for (int c = 0; c < 24; c++) begin
         tick();
         e_dig = ((c % 4) != 0) ? dig_tab[c / 4] : 6'h3F;
         e_seg = ((c % 4) != 0) ? exp_seg[c / 4] : 8'h00;
         e_fd  = (c == 23);
         checks++;
         if (dig_n !== e_dig) begin errors++; $display("FAIL dp dig_n c=%0d got=%h want=%h", c, dig_n, e_dig); end
         checks++;
         if (seg !== e_seg) begin errors++; $display("FAIL dp seg c=%0d got=%h want=%h", c, seg, e_seg); end
         checks++;
         if (frame_done !== e_fd) begin errors++; $display("FAIL dp frame_done c=%0d got=%b want=%b", c, frame_done, e_fd); end
      end
   endtask

   // Reset in slot 3 aborts the frame; first frame after shows blank shadow codes.
   task automatic test_reset_mid();
      logic [7:0] exp_a [6];
      logic [7:0] exp_b [6];
      logic [7:0] e_seg;
      logic [5:0] e_dig;
      logic       e_fd;
      exp_a = '{8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00};
      exp_b = '{8'h00, 8'h00, 8'h80, 8'h6D, 8'h3F, 8'h6F};
      repeat (13) tick();
      rst = 1'b1;
      tick();
      checks++;
      if (seg !== 8'h00) begin errors++; $display("FAIL midrst seg got=%h want=00", seg); end
      checks++;
      if (dig_n !== 6'h3F) begin errors++; $display("FAIL midrst dig_n got=%h want=3F", dig_n); end
      checks++;
      if (frame_done !== 1'b0) begin errors++; $display("FAIL midrst frame_done got=%b want=0", frame_done); end
      rst = 1'b0;
      for (int c = 0; c < 48; c++) begin
         tick();
         e_dig = ((c % 4) != 0) ? dig_tab[(c % 24) / 4] : 6'h3F;
         e_seg = ((c % 4) == 0) ? 8'h00 : (c < 24) ? exp_a[c / 4] : exp_b[(c - 24) / 4];
         e_fd  = ((c % 24) == 23);
         checks++;
         if (dig_n !== e_dig) begin errors++; $display("FAIL postrst dig_n c=%0d got=%h want=%h", c, dig_n, e_dig); end
         checks++;
         if (seg !== e_seg) begin errors++; $display("FAIL postrst seg c=%0d got=%h want=%h", c, seg, e_seg); end
         checks++;
         if (frame_done !== e_fd) begin errors++; $display("FAIL postrst frame_done c=%0d got=%b want=%b", c, frame_done, e_fd); end
      end
   endtask

   initial begin
      dig_tab = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
      test_reset();
      test_scan();
      test_shadow();
      test_blink();
      test_dp_blank();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
